// File: rtl/uart_core.sv
// uart_core: full-duplex UART with a shared baud tick, ready/valid byte ports and oversampled RX.
// Define UART_PARITY_EN to add a parity bit (odd when PARITY_ODD=1) on both directions.
module uart_core #(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 u_clk,
    input  logic                 u_rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
    localparam int BW  = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int CW  = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  BD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  SB_LAST = CW'(STOP_BITS - 1);
    localparam logic P_ODD = PARITY_ODD != 0;
`ifdef UART_PARITY_EN
    localparam logic P_EN = 1'b1;
`else
    localparam logic P_EN = 1'b0;
`endif

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

    logic [BW-1:0] r_baud_cnt;
    logic          w_tick;

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) r_baud_cnt <= '0;
        else r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 1'b1;
    end
    assign w_tick = r_baud_cnt == BD_LAST;

    tx_state_t            r_tx_state, w_tx_state_nx;
    logic [OSW-1:0]       r_tx_os;
    logic [CW-1:0]        r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, r_tx_wait;
    logic                 w_tx_adv, w_tx_last_data, w_tx_last_stop;

    // r_tx_wait holds the line high between acceptance and the first tick
    assign w_tx_adv       = w_tick && !r_tx_wait && r_tx_os == OS_LAST;
    assign w_tx_last_data = r_tx_bit == DB_LAST;
    assign w_tx_last_stop = r_tx_bit == SB_LAST;
    assign tx_ready       = r_tx_state == T_IDLE;
    assign tx = r_tx_state == T_START ? r_tx_wait :
                r_tx_state == T_DATA  ? r_tx_shift[0] :
                r_tx_state == T_PAR   ? r_tx_par : 1'b1;

    always_comb begin
        w_tx_state_nx = r_tx_state;
        case (r_tx_state)
            T_IDLE:  if (tx_valid) w_tx_state_nx = T_START;
            T_START: if (w_tx_adv) w_tx_state_nx = T_DATA;
            T_DATA:  if (w_tx_adv && w_tx_last_data) w_tx_state_nx = P_EN ? T_PAR : T_STOP;
            T_PAR:   if (w_tx_adv) w_tx_state_nx = T_STOP;
            T_STOP:  if (w_tx_adv && w_tx_last_stop) w_tx_state_nx = T_IDLE;
            default: w_tx_state_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            r_tx_state <= T_IDLE;
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_wait  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            if (r_tx_state == T_IDLE) begin
                if (tx_valid) begin
                    r_tx_shift <= tx_data;
                    r_tx_par   <= ^tx_data ^ P_ODD;
                    r_tx_wait  <= 1'b1;
                    r_tx_os    <= '0;
                    r_tx_bit   <= '0;
                end
            end else if (w_tick) begin
                if (r_tx_wait) r_tx_wait <= 1'b0;
                else if (r_tx_os != OS_LAST) r_tx_os <= r_tx_os + 1'b1;
                else begin
                    r_tx_os <= '0;
                    if (r_tx_state == T_DATA) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= w_tx_last_data ? '0 : r_tx_bit + 1'b1;
                    end else if (r_tx_state == T_STOP) r_tx_bit <= r_tx_bit + 1'b1;
                end
            end
        end
    end

    rx_state_t            r_rx_state, w_rx_state_nx;
    logic                 r_rx_s1, r_rx_s2;
    logic [OSW-1:0]       r_rx_os;
    logic [CW-1:0]        r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
    logic                 r_rx_pbit, r_rx_valid, r_rx_ovr, r_rx_ferr, r_rx_perr;
    logic                 w_rx, w_rx_mid, w_rx_half, w_par_bad, w_deliver, w_ferr, w_perr;

    assign w_rx      = r_rx_s2;
    assign w_rx_mid  = w_tick && r_rx_os == OS_LAST;
    assign w_rx_half = w_tick && r_rx_os == OS_HALF;
    assign w_par_bad = P_EN && (^r_rx_shift ^ r_rx_pbit ^ P_ODD);

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_deliver     = 1'b0;
        w_ferr        = 1'b0;
        w_perr        = 1'b0;
        case (r_rx_state)
            R_IDLE:  if (w_tick && !w_rx) w_rx_state_nx = R_START;
            R_START: if (w_rx_half) w_rx_state_nx = w_rx ? R_IDLE : R_DATA;
            R_DATA:  if (w_rx_mid && r_rx_bit == DB_LAST) w_rx_state_nx = P_EN ? R_PAR : R_STOP;
            R_PAR:   if (w_rx_mid) w_rx_state_nx = R_STOP;
            R_STOP: if (w_rx_mid) begin
                w_rx_state_nx = w_rx ? R_IDLE : R_WAIT;
                w_ferr        = !w_rx;
                w_perr        = w_par_bad;
                w_deliver     = w_rx && !w_par_bad;
            end
            R_WAIT:  if (w_tick && w_rx) w_rx_state_nx = R_IDLE;
            default: w_rx_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= R_IDLE;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_pbit  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_state <= w_rx_state_nx;
            if (w_tick)
                r_rx_os <= (r_rx_state inside {R_IDLE, R_WAIT} || (r_rx_state == R_START && w_rx_half)
                            || r_rx_os == OS_LAST) ? '0 : r_rx_os + 1'b1;
            if (w_rx_mid && r_rx_state == R_DATA) begin
                r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                r_rx_bit   <= r_rx_bit == DB_LAST ? '0 : r_rx_bit + 1'b1;
            end
            if (w_rx_mid && r_rx_state == R_PAR) r_rx_pbit <= w_rx;
            r_rx_ovr  <= w_deliver && r_rx_valid && !rx_ready;
            r_rx_ferr <= w_ferr;
            r_rx_perr <= w_perr;
            // a new word may replace one being read in the same cycle
            if (w_deliver && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (rx_ready) r_rx_valid <= 1'b0;
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_overrun    = r_rx_ovr;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_parity_err = P_EN && r_rx_perr;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed-plus-random bench for uart_core with a frame-level reference model.
module tb_uart_core;
    localparam int BD = 4, OS = 16, DB = 8, SB = 1, PODD = 0;
`ifdef UART_PARITY_EN
    localparam int PN = 1;
`else
    localparam int PN = 0;
`endif
    localparam int BIT = BD * OS;
    localparam int NBITS = 1 + DB + PN + SB;

    logic clk = 0, rst_n = 0;
    logic [7:0] tx_data = 0;
    logic tx_valid = 0, rx_ready = 1, loop = 0, rx_drv = 1;
    logic tx_ready, tx, rx, rx_valid, rx_overrun, rx_frame_err, rx_parity_err;
    logic [7:0] rx_data;
    int n_cmp = 0, n_fail = 0, n_ovr = 0, n_ferr = 0, n_perr = 0;
    logic [7:0] got[$], exp_q[$];

    assign rx = loop ? tx : rx_drv;

    uart_core #(.BAUD_DIV(BD), .OVERSAMPLE(OS), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
        .u_clk(clk), .u_rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx(tx), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err));

    always #5 clk = ~clk;

    // consumer side: log handshakes and error pulses just after each falling edge
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            n_ovr  += int'(rx_overrun);
            n_ferr += int'(rx_frame_err);
            n_perr += int'(rx_parity_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic par_of(input logic [7:0] d);
        return ^d ^ (PODD != 0);
    endfunction

    task automatic send_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 4 * NBITS * BIT) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data = d;
        tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
    endtask

    task automatic check_tx_frame(input logic [7:0] d);
        logic eb[$];
        int n = 0, cyc = 0;
        eb.push_back(1'b0);
        for (int i = 0; i < DB; i++) eb.push_back(d[i]);
        if (PN != 0) eb.push_back(par_of(d));
        for (int i = 0; i < SB; i++) eb.push_back(1'b1);
        send_tx(d);
        chk("tx_ready_fall", tx_ready, 0);
        while (tx !== 1'b0 && n < BD + 2) begin
            @(negedge clk);
            n++;
        end
        chk("tx_start_latency", n >= 1 && n <= BD, 1);
        for (int i = 0; i < eb.size(); i++) begin
            repeat (i == 0 ? BIT / 2 - 1 : BIT) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("tx_%02h_bit%0d", d, i), tx, eb[i]);
        end
        while (!tx_ready && cyc < NBITS * BIT + BIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("tx_frame_cycles", cyc, NBITS * BIT);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic bad_par, input int stop_low);
        rx_drv = 0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_drv = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (PN != 0) begin
            rx_drv = par_of(d) ^ bad_par;
            repeat (BIT) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx_drv = 0;
            repeat (stop_low * BIT) @(negedge clk);
        end
        rx_drv = 1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] lb[4];
        logic [7:0] d;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        chk("rst_parity_err", rx_parity_err, 0);
        rst_n = 1;
        @(negedge clk);

        check_tx_frame(8'hA5);
        check_tx_frame(8'h01);
        check_tx_frame(8'($urandom));

        loop = 1;
        rx_ready = 1;
        lb = '{8'h3C, 8'hC3, 8'($urandom), 8'($urandom)};
        foreach (lb[i]) begin
            send_tx(lb[i]);
            exp_q.push_back(lb[i]);
        end
        n = 0;
        while (!tx_ready && n < 2 * NBITS * BIT) begin
            @(negedge clk);
            n++;
        end
        repeat (BIT) @(negedge clk);
        loop = 0;
        check_rx("loopback");
        chk("loop_frame_err", n_ferr, 0);
        chk("loop_parity_err", n_perr, 0);
        chk("loop_overrun", n_ovr, 0);

        rx_drv = 0;
        repeat (3 * BD) @(negedge clk);
        rx_drv = 1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_rx_valid", rx_valid, 0);
        chk("glitch_frame_err", n_ferr, 0);
        d = 8'($urandom);
        drive_rx(d, 0, 0);
        exp_q.push_back(d);
        repeat (10) @(negedge clk);
        check_rx("after_glitch");

        rx_ready = 0;
        drive_rx(8'h12, 0, 0);
        drive_rx(8'h34, 0, 0);
        repeat (10) @(negedge clk);
        chk("ovr_rx_valid", rx_valid, 1);
        chk("ovr_rx_data", rx_data, 8'h12);
        chk("ovr_pulses", n_ovr, 1);
        rx_ready = 1;
        exp_q.push_back(8'h12);
        @(negedge clk);
        #2;
        chk("ovr_cleared", rx_valid, 0);
        check_rx("overrun");

        drive_rx(8'($urandom), 0, 40);
        repeat (10) @(negedge clk);
        chk("break_frame_err", n_ferr, 1);
        chk("break_rx_valid", rx_valid, 0);
        drive_rx(8'h55, 0, 0);
        exp_q.push_back(8'h55);
        repeat (10) @(negedge clk);
        check_rx("after_break");
        chk("break_frame_err_once", n_ferr, 1);

`ifdef UART_PARITY_EN
        drive_rx(8'h01, 1, 0);
        repeat (10) @(negedge clk);
        chk("parity_err_pulse", n_perr, 1);
        chk("parity_rx_valid", rx_valid, 0);
        check_rx("parity");
`endif

        rx_ready = 0;
        drive_rx(8'hE7, 0, 0);
        repeat (10) @(negedge clk);
        chk("pre_reset_rx_valid", rx_valid, 1);
        send_tx(8'($urandom));
        repeat (3 * BIT) @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("midreset_tx", tx, 1);
        chk("midreset_tx_ready", tx_ready, 1);
        chk("midreset_rx_valid", rx_valid, 0);
        chk("midreset_rx_data", rx_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("post_reset_tx", tx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART with shared baud-tick generator, ready/valid byte interfaces on both directions, configurable data bits and stop bits, and 16x (configurable) oversampled receive with start-bit glitch rejection and error flags. Sits between the serial pins and any byte-stream client, replacing the separate fixed-width transmitter/receiver pair with one clock domain and a proper handshake.

## Interface

- BAUD_DIV, 27: clock cycles per oversample tick; ≥1.
- OVERSAMPLE, 16: ticks per serial bit; even, ≥4.
- DATA_BITS, 8: data bits per frame; 5..9.
- STOP_BITS, 1: stop bits transmitted; 1 or 2 (receiver checks the first only).
- PARITY_ODD, 0: 1 = odd parity, 0 = even; used only under UART_PARITY_EN.
- u_clk  in  1  sole clock, rising edge.
- u_rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter idle; transfer on tx_valid && tx_ready.
- tx  out  1  serial out, idle high.
- rx  in  1  serial in, asynchronous.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer accepts; clears rx_valid.
- rx_overrun  out  1  one-cycle pulse: word completed while rx_valid high.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_parity_err  out  1  one-cycle pulse: parity mismatch.

## Operation

- Tick generator: counter 0..BAUD_DIV-1, width $clog2(BAUD_DIV) (min 1); tick high for one cycle when counter = BAUD_DIV-1. Free-running; shared by TX and RX.
- TX FSM: IDLE, START, DATA, PARITY, STOP. IDLE: tx_ready=1, tx=1; accept captures tx_data into shift register. Frame begins on the next tick: START (tx=0), DATA (LSB first), PARITY (if enabled), STOP (tx=1, STOP_BITS bits). Each bit lasts exactly OVERSAMPLE ticks. After the last stop bit, return to IDLE.
- RX: rx passes a 2-flop synchroniser (reset to 1). FSM IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; all advances on ticks.
  - IDLE: synced rx=0 on a tick -> START, sample count cleared.
  - START: at count OVERSAMPLE/2-1 re-sample; 0 -> DATA, count cleared; 1 -> IDLE (glitch rejected, no flag).
  - DATA: sample every OVERSAMPLE ticks (mid-bit), shift in LSB first; after DATA_BITS samples -> PARITY or STOP.
  - STOP: mid-bit sample 1 -> deliver word, IDLE; 0 -> rx_frame_err pulse, word discarded, WAIT_HIGH.
  - WAIT_HIGH: stays until synced rx=1 on a tick, then IDLE (break condition yields one flag only).
- Delivery: if rx_valid=0, load rx_data, set rx_valid. If rx_valid=1 (including its clear in the same cycle being absent), pulse rx_overrun, keep old rx_data, drop new word. rx_valid && rx_ready clears rx_valid next cycle; a delivery in the same cycle as a clear loads the new word and keeps rx_valid=1, no overrun.
- Reset (any time, mid-frame included): tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error pulses 0, both FSMs IDLE, all counters 0. Takes effect asynchronously.

## Timing

- tx_ready falls the cycle after acceptance; rises the cycle after the final stop bit's last tick.
- tx falls on the first tick after acceptance: 1..BAUD_DIV cycles latency.
- Frame length: OVERSAMPLE*(1+DATA_BITS+P+STOP_BITS) ticks, P = 1 with parity else 0.
- RX returns to IDLE at mid-stop-bit, so back-to-back frames with one stop bit are received without loss.
- rx_valid rises the cycle after the mid-stop sample tick; error pulses coincide with it.

## Configuration

- UART_PARITY_EN defined: TX inserts one parity bit after data (even, or odd when PARITY_ODD=1); RX checks it; mismatch -> rx_parity_err pulse at mid-stop-bit decision cycle, word discarded (not delivered, no overrun).
- Undefined: no parity bit on either side, PARITY states unreachable, rx_parity_err tied 0.

## Test plan

- BAUD_DIV=4, OVERSAMPLE=16, DATA_BITS=8: send 0xA5 -> tx levels 0,1,0,1,0,0,1,0,1,1, each 64 cycles; tx_ready low for 640 cycles.
- Loop tx to rx, send 0x3C then 0xC3 back-to-back with rx_ready=1 -> rx_valid twice, rx_data 0x3C then 0xC3, no error pulses.
- rx low for 3 ticks then high -> no rx_valid, no flags, FSM back to IDLE.
- Two frames 0x12, 0x34 with rx_ready=0 -> rx_data=0x12, one rx_overrun pulse; rx_ready=1 clears rx_valid.
- Stop bit driven 0 for 40 bit times -> exactly one rx_frame_err pulse, no rx_valid; next clean frame 0x55 received.
- UART_PARITY_EN, even: send 0x01 -> parity bit 1; inject parity 0 on rx -> rx_parity_err pulse, no rx_valid. Assert u_rst_n low mid-DATA -> tx=1, tx_ready=1 immediately.
